ahbl_master_arbiter: RTL and testbench
======================================

// Module: ahbl_master_arbiter
// PURPOSE
//  Round-robin arbiter letting NUM_M AHB-Lite masters (core data port, debug/DMA) share one
//  AHB-Lite downstream port, i.e. the data fabric ahblite. Every master address phase is
//  registered, then issued downstream in arbitration order. Each transfer gets exactly one added
//  wait state. Transfers are pipelined and the hmastlock sequences are honoured.
// PARAMETERS
//  ADDR_WIDTH  32  address width (system_pkg value)
//  DATA_WIDTH  32  data width (system_pkg value)
//  NUM_M       2   number of masters, 2..4
// PORTS
//  clk          in   1                 system clock
//  rstn         in   1                 synchronous active-low reset
//  m_haddr      in   [NUM_M][ADDR_W]   master addresses
//  m_htrans     in   [NUM_M][2]        master transfer types
//  m_hwrite     in   [NUM_M]           master write flags
//  m_hsize      in   [NUM_M][3]        master transfer sizes
//  m_hmastlock  in   [NUM_M]           master lock requests
//  m_hwdata     in   [NUM_M][DATA_W]   master write data (data phase)
//  m_hrdata     out  [NUM_M][DATA_W]   read data (all entries = s_hrdata)
//  m_hready     out  [NUM_M]           per-master ready
//  m_hresp      out  [NUM_M]           per-master error response
//  s_haddr      out  ADDR_W            downstream address
//  s_htrans     out  2                 downstream transfer type (IDLE or NONSEQ only)
//  s_hwrite     out  1                 downstream write flag
//  s_hsize      out  3                 downstream transfer size
//  s_hmastlock  out  1                 downstream lock
//  s_hwdata     out  DATA_W            = m_hwdata[dph_owner]
//  s_hrdata     in   DATA_W            downstream read data
//  s_hready     in   1                 downstream ready
//  s_hresp      in   1                 downstream error response
// BEHAVIOUR
//  Reset (sync, rstn=0 at posedge):
//   - Clears pend_vld[], aph_vld, dph_vld, lock_vld. Sets rr_last=NUM_M-1.
//   - Outputs: m_hready=all 1, m_hresp=0, s_htrans=IDLE, s_haddr=0, s_hwrite=0, s_hmastlock=0.
//   - Mid-operation reset drops all pending and in-flight transfers; no completion is reported.
//  Capture:
//   - At a posedge with m_hready[m]=1 and m_htrans[m][1]=1, latch {haddr,hwrite,hsize,hmastlock}
//     into pend[m] and set pend_vld[m]. SEQ is treated as NONSEQ.
//   - IDLE/BUSY are never captured.
//  m_hready[m]:
//   - = s_hready when dph_vld and dph_owner==m.
//   - Else = 0 while pend_vld[m], or while m owns the current address phase.
//   - Else = 1.
//   - m_hresp[m] = s_hresp when m is the data-phase owner, else 0.
//  Grant:
//   - Evaluated when no address phase is held (aph_vld=0), or when the held phase is accepted.
//   - Picks the first pend_vld index after rr_last (circular), then sets rr_last = winner.
//   - If lock_vld, only lock_owner is eligible.
//   - The winner's pend drives s_* with s_htrans=NONSEQ. s_htrans=IDLE when no pend is eligible.
//  Address phase hold: while s_hready=0, s_haddr/ctrl/htrans stay stable and the grant is frozen.
//  Address accepted (posedge, s_hready=1):
//   - Clears pend_vld[winner].
//   - Sets dph_vld and dph_owner=winner.
//   - Loads lock_vld=pend.hmastlock and lock_owner=winner.
//   - dph_vld clears at the next s_hready=1 unless a new address phase is accepted.
//  Pipelining:
//   - A different master's address phase may overlap the current data phase.
//   - Master m's next capture happens in the same cycle its data phase completes.
//  ERROR: two-cycle s_hresp passes to the owner unchanged. Other masters' pends are unaffected.
//  Simultaneous captures from several masters in one cycle are all pended, then served in rr order.
// TESTING
//  1 m0 read 0x0000_0100, zero-wait slave -> s_htrans=NONSEQ 1 cycle later; m0_hready low exactly
//    1 cycle; m0_hrdata=0xDEAD_BEEF.
//  2 m0, m1 write same cycle after reset -> m0 issued first, m1 next cycle (pipelined);
//    m1_hready low 2 cycles; s_hwdata switches owner correctly.
//  3 m0 two transfers with hmastlock=1 then one with 0, m1 pending -> m1 issued only after m0's
//    unlocked transfer.
//  4 Slave inserts 2 wait states on m0 data while m1 pends -> m1 address held stable on s_haddr
//    for 3 cycles; m0_hready low.
//  5 Slave ERROR on m1 -> m1_hresp=1 for 2 cycles with m1_hready 0 then 1; m0 sees hresp=0.
//  6 rstn=0 mid data phase -> next cycle m_hready=all 1, s_htrans=IDLE, pend_vld=0.

Source files
------------

// File: rtl/ahbl_master_arbiter.sv
// Round-robin arbiter merging NUM_M AHB-Lite masters onto one downstream AHB-Lite port.
// Every master address phase is registered first, which costs each transfer one wait state.
module ahbl_master_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_M      = 2
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NUM_M-1:0][ADDR_WIDTH-1:0] m_haddr,
  input  logic [NUM_M-1:0][1:0]            m_htrans,
  input  logic [NUM_M-1:0]                 m_hwrite,
  input  logic [NUM_M-1:0][2:0]            m_hsize,
  input  logic [NUM_M-1:0]                 m_hmastlock,
  input  logic [NUM_M-1:0][DATA_WIDTH-1:0] m_hwdata,
  output logic [NUM_M-1:0][DATA_WIDTH-1:0] m_hrdata,
  output logic [NUM_M-1:0]                 m_hready,
  output logic [NUM_M-1:0]                 m_hresp,
  output logic [ADDR_WIDTH-1:0]            s_haddr,
  output logic [1:0]                       s_htrans,
  output logic                             s_hwrite,
  output logic [2:0]                       s_hsize,
  output logic                             s_hmastlock,
  output logic [DATA_WIDTH-1:0]            s_hwdata,
  input  logic [DATA_WIDTH-1:0]            s_hrdata,
  input  logic                             s_hready,
  input  logic                             s_hresp
);

  localparam int         IW        = (NUM_M > 2) ? 2 : 1;
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  // Handshakes: a master phase is taken at a posedge with m_htrans NONSEQ/SEQ and
  // m_hready[m]=1; the downstream phase is taken at a posedge with s_htrans=NONSEQ and s_hready=1.

  logic [NUM_M-1:0][ADDR_WIDTH-1:0] pend_addr;
  logic [NUM_M-1:0][2:0]            pend_size;
  logic [NUM_M-1:0]                 pend_write;
  logic [NUM_M-1:0]                 pend_lock;
  logic [NUM_M-1:0]                 pend_vld;
  logic [NUM_M-1:0]                 capture;
  logic [NUM_M-1:0]                 elig;

  logic          aph_vld;
  logic [IW-1:0] aph_owner;
  logic          dph_vld;
  logic [IW-1:0] dph_owner;
  logic          lock_vld;
  logic [IW-1:0] lock_owner;
  logic [IW-1:0] rr_last;

  logic          hi_found, lo_found;
  logic [IW-1:0] hi_pick, lo_pick;
  logic          gnt_vld;
  logic [IW-1:0] gnt_idx;
  logic          accept;

  always_comb begin
    for (int j = 0; j < NUM_M; j++) begin
      capture[j] = m_hready[j] && (m_htrans[j] == HT_NONSEQ || m_htrans[j] == HT_SEQ);
      elig[j]    = pend_vld[j] && (!lock_vld || lock_owner == IW'(j));
    end
  end

  // Circular search after rr_last: prefer the lowest eligible index above rr_last,
  // otherwise wrap to the lowest eligible index overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_pick  = '0;
    lo_pick  = '0;
    for (int j = NUM_M - 1; j >= 0; j--) begin
      if (elig[j]) begin
        lo_found = 1'b1;
        lo_pick  = IW'(j);
        if (IW'(j) > rr_last) begin
          hi_found = 1'b1;
          hi_pick  = IW'(j);
        end
      end
    end
  end

  // A phase stalled by s_hready=0 keeps its owner even if new requests arrive.
  assign gnt_vld = aph_vld || lo_found;
  assign gnt_idx = aph_vld ? aph_owner : (hi_found ? hi_pick : lo_pick);
  assign accept  = gnt_vld && s_hready;

  always_ff @(posedge clk) begin
    for (int j = 0; j < NUM_M; j++) begin
      if (capture[j]) begin
        pend_addr[j]  <= m_haddr[j];
        pend_size[j]  <= m_hsize[j];
        pend_write[j] <= m_hwrite[j];
        pend_lock[j]  <= m_hmastlock[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend_vld   <= '0;
      aph_vld    <= 1'b0;
      aph_owner  <= '0;
      dph_vld    <= 1'b0;
      dph_owner  <= '0;
      lock_vld   <= 1'b0;
      lock_owner <= '0;
      rr_last    <= IW'(NUM_M - 1);
    end else begin
      for (int j = 0; j < NUM_M; j++) begin
        if (capture[j]) begin
          pend_vld[j] <= 1'b1;
        end else if (accept && gnt_idx == IW'(j)) begin
          pend_vld[j] <= 1'b0;
        end
      end
      aph_vld <= gnt_vld && !s_hready;
      if (gnt_vld) begin
        aph_owner <= gnt_idx;
      end
      if (accept) begin
        dph_vld    <= 1'b1;
        dph_owner  <= gnt_idx;
        lock_vld   <= pend_lock[gnt_idx];
        lock_owner <= gnt_idx;
        rr_last    <= gnt_idx;
      end else if (s_hready) begin
        dph_vld <= 1'b0;
      end
    end
  end

  // Between locked transfers the downstream lock stays asserted through IDLE cycles.
  always_comb begin
    s_htrans    = HT_IDLE;
    s_haddr     = '0;
    s_hwrite    = 1'b0;
    s_hsize     = '0;
    s_hmastlock = lock_vld;
    if (gnt_vld) begin
      s_htrans    = HT_NONSEQ;
      s_haddr     = pend_addr[gnt_idx];
      s_hwrite    = pend_write[gnt_idx];
      s_hsize     = pend_size[gnt_idx];
      s_hmastlock = pend_lock[gnt_idx];
    end
    s_hwdata = m_hwdata[dph_owner];
    for (int j = 0; j < NUM_M; j++) begin
      m_hrdata[j] = s_hrdata;
      m_hready[j] = 1'b1;
      m_hresp[j]  = 1'b0;
      if (dph_vld && dph_owner == IW'(j)) begin
        m_hready[j] = s_hready;
        m_hresp[j]  = s_hresp;
      end else if (pend_vld[j]) begin
        m_hready[j] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahbl_master_arbiter.sv
// Randomized bench for ahbl_master_arbiter: master drivers and a slave responder feed a
// scoreboard whose monitor predicts grant order, locking, ready/response and data routing.
module tb_ahbl_master_arbiter;

  localparam int NM     = 3;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int EW     = 1 + 3 + 1 + AW + DW;
  localparam int N_CYC  = 3000;
  localparam int RST_CYC = 1500;

  typedef struct packed {
    logic          lock;
    logic [2:0]    size;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } xfer_t;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [NM-1:0][AW-1:0] m_haddr;
  logic [NM-1:0][1:0]    m_htrans;
  logic [NM-1:0]         m_hwrite;
  logic [NM-1:0][2:0]    m_hsize;
  logic [NM-1:0]         m_hmastlock;
  logic [NM-1:0][DW-1:0] m_hwdata;
  logic [NM-1:0][DW-1:0] m_hrdata;
  logic [NM-1:0]         m_hready;
  logic [NM-1:0]         m_hresp;
  logic [AW-1:0]         s_haddr;
  logic [1:0]            s_htrans;
  logic                  s_hwrite;
  logic [2:0]            s_hsize;
  logic                  s_hmastlock;
  logic [DW-1:0]         s_hwdata;
  logic [DW-1:0]         s_hrdata;
  logic                  s_hready;
  logic                  s_hresp;

  ahbl_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_M(NM)) dut (
    .clk(clk), .rstn(rstn),
    .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
    .m_hmastlock(m_hmastlock), .m_hwdata(m_hwdata), .m_hrdata(m_hrdata),
    .m_hready(m_hready), .m_hresp(m_hresp),
    .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
    .s_hmastlock(s_hmastlock), .s_hwdata(s_hwdata), .s_hrdata(s_hrdata),
    .s_hready(s_hready), .s_hresp(s_hresp)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q [NM][$];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic  done    = 1'b0;
  logic  mdph_vld = 1'b0;
  xfer_t mdph;
  int    mdph_own;
  int    m_rr;
  logic  m_lock;
  int    m_lock_own;
  logic  held;
  int    held_m;
  logic  just_reset;

  // driver state
  xfer_t         cur [NM];
  logic [NM-1:0] drv_req;
  int            gap [NM];
  int            lock_left [NM];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Next owner: first master after m_rr (circular) holding a captured transfer,
  // restricted to the lock holder while a locked sequence is open.
  function automatic int pick();
    int c;
    for (int k = 1; k <= NM; k++) begin
      c = (m_rr + k) % NM;
      if (exp_q[c].size() != 0 && (!m_lock || c == m_lock_own)) return c;
    end
    return -1;
  endfunction

  task automatic new_req(input int m);
    if (lock_left[m] == 0 && $urandom_range(0, 7) == 0) lock_left[m] = $urandom_range(2, 3);
    cur[m].lock = (lock_left[m] > 1);
    if (lock_left[m] > 0) lock_left[m]--;
    cur[m].addr  = $urandom;
    cur[m].write = 1'($urandom_range(0, 1));
    cur[m].size  = 3'($urandom_range(0, 2));
    cur[m].wdata = $urandom;
    m_haddr[m]     = cur[m].addr;
    m_hwrite[m]    = cur[m].write;
    m_hsize[m]     = cur[m].size;
    m_hmastlock[m] = cur[m].lock;
    m_htrans[m]    = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b10;
    drv_req[m]     = 1'b1;
  endtask

  // ---------------- stimulus: reset + master drivers ----------------
  initial begin : stim
    logic [NM-1:0] cap;
    logic          rst_edge;
    rstn = 1'b0;
    m_haddr = '0; m_htrans = '0; m_hwrite = '0; m_hsize = '0; m_hmastlock = '0; m_hwdata = '0;
    drv_req = '0;
    for (int m = 0; m < NM; m++) begin
      gap[m] = 0;
      lock_left[m] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      rst_edge = !rstn;
      for (int m = 0; m < NM; m++) cap[m] = rstn && drv_req[m] && (m_htrans[m][1] == 1'b1) && m_hready[m];
      @(posedge clk);
      #1;
      rstn = !(cyc == RST_CYC);
      for (int m = 0; m < NM; m++) begin
        if (rst_edge) begin
          drv_req[m] = 1'b0;
          lock_left[m] = 0;
          gap[m] = $urandom_range(0, 2);
          m_htrans[m] = 2'b00;
          continue;
        end
        if (cap[m]) begin
          exp_q[m].push_back(cur[m]);
          m_hwdata[m] = cur[m].wdata;
          drv_req[m] = 1'b0;
          gap[m] = $urandom_range(0, 3);
        end
        if (!drv_req[m]) begin
          if (gap[m] == 0) new_req(m);
          else begin
            gap[m]--;
            m_htrans[m] = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
            m_haddr[m]  = $urandom;
          end
        end
      end
    end
    done = 1'b1;
  end

  // ---------------- slave responder ----------------
  initial begin : slave
    logic err_ph;
    err_ph = 1'b0;
    s_hready = 1'b1;
    s_hresp  = 1'b0;
    s_hrdata = '0;
    forever begin
      @(posedge clk);
      #1;
      s_hrdata = $urandom;
      if (!mdph_vld) begin
        err_ph = 1'b0;
        s_hresp = 1'b0;
        s_hready = 1'b1;
      end else if (err_ph) begin
        err_ph = 1'b0;
        s_hresp = 1'b1;
        s_hready = 1'b1;
      end else if ($urandom_range(0, 15) == 0) begin
        err_ph = 1'b1;
        s_hresp = 1'b1;
        s_hready = 1'b0;
      end else begin
        s_hresp = 1'b0;
        s_hready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    int            wm;
    xfer_t         e;
    logic [NM-1:0] eh, er;
    m_rr = NM - 1; m_lock = 1'b0; m_lock_own = 0; mdph_own = 0; mdph = '0;
    held = 1'b0; held_m = 0; just_reset = 1'b1;
    while (1) begin
      @(negedge clk);
      if (done) break;
      if (!rstn) begin
        for (int m = 0; m < NM; m++) exp_q[m].delete();
        m_rr = NM - 1; m_lock = 1'b0; mdph_vld = 1'b0; held = 1'b0; just_reset = 1'b1;
        continue;
      end
      wm = held ? held_m : pick();
      eh = '1;
      er = '0;
      for (int m = 0; m < NM; m++) begin
        if (mdph_vld && mdph_own == m) begin
          eh[m] = s_hready;
          er[m] = s_hresp;
        end else if (exp_q[m].size() != 0) begin
          eh[m] = 1'b0;
        end
      end
      check("m_hready", 128'(m_hready), 128'(eh));
      check("m_hresp", 128'(m_hresp), 128'(er));
      check("s_htrans", 128'(s_htrans), (wm >= 0) ? 128'd2 : 128'd0);
      e = '0;
      if (wm >= 0) begin
        e = exp_q[wm][0];
        check("s_haddr", 128'(s_haddr), 128'(e.addr));
        check("s_ctrl", 128'({s_hwrite, s_hsize, s_hmastlock}), 128'({e.write, e.size, e.lock}));
      end
      if (just_reset) check("reset_outputs", 128'({s_haddr, s_hwrite, s_hmastlock}), 128'd0);
      just_reset = 1'b0;
      if (mdph_vld && mdph.write) check("s_hwdata", 128'(s_hwdata), 128'(mdph.wdata));
      check("m_hrdata", 128'(m_hrdata), 128'({NM{s_hrdata}}));
      if (wm >= 0 && s_hready) begin
        mdph = e;
        mdph_own = wm;
        mdph_vld = 1'b1;
        m_lock = e.lock;
        m_lock_own = wm;
        m_rr = wm;
        void'(exp_q[wm].pop_front());
        held = 1'b0;
      end else begin
        if (s_hready) mdph_vld = 1'b0;
        held = (wm >= 0);
        held_m = wm;
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
